tri_bbox_scanner: RTL and testbench
===================================

Name: tri_bbox_scanner

Overview:
Upstream pixel-generation stage for the triangle pixel evaluator. Accepts one triangle (three Q16.16 vertices plus per-vertex colours) over a valid/ready handshake, computes its screen-clamped integer bounding box, and streams every sample coordinate in that box, one per cycle, with backpressure. The latched triangle attributes are held stable on its outputs so the evaluator sees the triangle and the pixel together.

Parameters:
CORDW, 10, screen coordinate width in bits
H_RES, 640, horizontal resolution; x is clamped to 0..H_RES-1
V_RES, 480, vertical resolution; y is clamped to 0..V_RES-1

Ports:
clk_pix  in  1  pixel clock
rst_pix_n  in  1  synchronous active-low reset
tri_valid  in  1  triangle offered
tri_ready  out  1  block can accept a triangle
tri_ax, tri_ay, tri_az, tri_bx, tri_by, tri_bz, tri_cx, tri_cy, tri_cz  in  32 each  signed Q16.16 vertex coordinates
tri_a_color, tri_b_color, tri_c_color  in  12 each  RGB444 vertex colours
q_ax … q_cz  out  32 each  latched vertex coordinates, stable from accept until the next accept
q_a_color, q_b_color, q_c_color  out  12 each  latched colours, same stability rule
pix_valid  out  1  pixel coordinate valid
pix_ready  in  1  downstream consumes the pixel
pix_x, pix_y  out  CORDW  integer screen coordinate
pix_px, pix_py  out  32  pixel coordinate in Q16.16 (pix_x<<16, pix_y<<16)
pix_first, pix_last  out  1  first / last pixel of the triangle
done  out  1  one-cycle pulse when the triangle is finished
busy  out  1  high in SETUP or SCAN

Behaviour:
- Reset (rst_pix_n low at a clk_pix edge):
  - State goes to IDLE.
  - pix_valid, done, busy, pix_first, pix_last, pix_x/y, pix_px/py and all q_* outputs become 0.
  - tri_ready is forced to 0 while rst_pix_n is low.
  - Reset mid-scan abandons the triangle; no done pulse is issued.
- IDLE:
  - tri_ready=1.
  - On tri_valid && tri_ready, latch all tri_* inputs into q_*, then go to SETUP.
- SETUP (exactly 1 cycle), bounding box computed in 32-bit signed:
  - xmin = ceil(min(ax,bx,cx)), computed as (v+0xFFFF)>>>16.
  - xmax = floor(max(...)), computed as v>>>16.
  - ymin and ymax use the same rules on the y coordinates.
  - Clamp xmin/xmax to [0,H_RES-1] and ymin/ymax to [0,V_RES-1].
  - If the unclamped xmin>xmax or ymin>ymax, or the box lies fully off-screen (xmin>H_RES-1, xmax<0, ymin>V_RES-1, ymax<0): go to IDLE and pulse done on the next cycle. No pixels are emitted.
  - Otherwise set x=xmin, y=ymin and go to SCAN.
- SCAN:
  - pix_valid=1.
  - On pix_valid && pix_ready:
    - if x==xmax and y==ymax: go to IDLE and pulse done on the next cycle;
    - else if x==xmax: x=xmin, y=y+1;
    - else x=x+1.
  - While pix_ready=0, all pix_* outputs hold stable.
- Flags:
  - pix_first = (x==xmin && y==ymin).
  - pix_last = (x==xmax && y==ymax).
  - A single-pixel box asserts both.
- Timing:
  - Latency: triangle accepted at edge N; pix_valid is first high in the cycle after edge N+1.
  - Throughput: 1 pixel/cycle with pix_ready held high.
  - Pixel count = (xmax-xmin+1)*(ymax-ymin+1).
- Zero-area triangles are scanned normally; rejection is the evaluator's job.
- done and tri_ready may be high in the same cycle. A back-to-back triangle is accepted at the first IDLE edge.
- pix_valid must never depend combinationally on pix_ready.

Test Plan:
1. Vertices (100,50),(200,300),(300,100), pix_ready=1 → 201×251=50451 pixels in raster order; first (100,50), last (300,300); pix_valid high 2 cycles after accept; exactly one done pulse.
2. Same triangle with random pix_ready (~50%) → identical sequence; pix_* stable during stalls; no drops or duplicates; q_* unchanged throughout.
3. Vertices (-10.5,-5),(700,10),(20,500) → box x 0..639, y 0..479; first (0,0), last (639,479).
4. Vertices (5,7),(5.5,7.5),(5.75,7) → one pixel (5,7) with pix_first=pix_last=1, then done. Vertices (5.25,7),(5.5,7),(5.75,8) → zero pixels, done pulse, no pix_valid.
5. All x ≥ 700 → no pix_valid, done 2 cycles after accept, tri_ready back high.
6. Assert rst_pix_n=0 after 10 pixels of test 1 → pix_valid=0 and tri_ready=0 next cycle, no done. After release, tri_ready=1; a new triangle scans from its own pix_first.

Source files
------------

// File: rtl/tri_bbox_scanner_if.sv
// Triangle-in / pixel-out bus between the triangle source, the bounding-box
// scanner and the downstream pixel evaluator.
interface tri_bbox_scanner_if #(
   parameter int CORDW = 10
);
   logic                    tri_valid;
   logic                    tri_ready;
   logic signed [31:0]      tri_ax, tri_ay, tri_az;
   logic signed [31:0]      tri_bx, tri_by, tri_bz;
   logic signed [31:0]      tri_cx, tri_cy, tri_cz;
   logic        [11:0]      tri_a_color, tri_b_color, tri_c_color;

   logic signed [31:0]      q_ax, q_ay, q_az;
   logic signed [31:0]      q_bx, q_by, q_bz;
   logic signed [31:0]      q_cx, q_cy, q_cz;
   logic        [11:0]      q_a_color, q_b_color, q_c_color;

   logic                    pix_valid;
   logic                    pix_ready;
   logic        [CORDW-1:0] pix_x, pix_y;
   logic        [31:0]      pix_px, pix_py;
   logic                    pix_first, pix_last;
   logic                    done;
   logic                    busy;

   modport master (
      output tri_valid, tri_ax, tri_ay, tri_az, tri_bx, tri_by, tri_bz,
             tri_cx, tri_cy, tri_cz, tri_a_color, tri_b_color, tri_c_color,
             pix_ready,
      input  tri_ready, q_ax, q_ay, q_az, q_bx, q_by, q_bz, q_cx, q_cy, q_cz,
             q_a_color, q_b_color, q_c_color, pix_valid, pix_x, pix_y,
             pix_px, pix_py, pix_first, pix_last, done, busy
   );

   modport slave (
      input  tri_valid, tri_ax, tri_ay, tri_az, tri_bx, tri_by, tri_bz,
             tri_cx, tri_cy, tri_cz, tri_a_color, tri_b_color, tri_c_color,
             pix_ready,
      output tri_ready, q_ax, q_ay, q_az, q_bx, q_by, q_bz, q_cx, q_cy, q_cz,
             q_a_color, q_b_color, q_c_color, pix_valid, pix_x, pix_y,
             pix_px, pix_py, pix_first, pix_last, done, busy
   );
endinterface

// File: rtl/tri_bbox_scanner.sv
// Latches one triangle, computes its screen-clamped integer bounding box and
// streams every sample coordinate in raster order with valid/ready backpressure.
module tri_bbox_scanner #(
   parameter int CORDW = 10,
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic clk_pix,
   input  logic rst_pix_n,
   tri_bbox_scanner_if.slave bus
);
   localparam logic signed [31:0] X_LIM = 32'(H_RES - 1);
   localparam logic signed [31:0] Y_LIM = 32'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

   state_t                 state_reg;
   logic                   tri_ready_reg, pix_valid_reg, done_reg, busy_reg;
   logic                   pix_first_reg, pix_last_reg;
   logic       [CORDW-1:0] x_reg, y_reg, xmin_reg, xmax_reg, ymin_reg;
   logic       [CORDW-1:0] ymax_reg, x_next, y_next;
   logic signed [31:0]     q_ax_reg, q_ay_reg, q_az_reg, q_bx_reg, q_by_reg;
   logic signed [31:0]     q_bz_reg, q_cx_reg, q_cy_reg, q_cz_reg;
   logic        [11:0]     q_a_color_reg, q_b_color_reg, q_c_color_reg;

   logic signed [31:0]     xmin_u, xmax_u, ymin_u, ymax_u;
   logic signed [31:0]     xmin_c, xmax_c, ymin_c, ymax_c;
   logic                   box_empty;

   function automatic logic signed [31:0] min3(input logic signed [31:0] a,
                                               input logic signed [31:0] b,
                                               input logic signed [31:0] c);
      logic signed [31:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [31:0] max3(input logic signed [31:0] a,
                                               input logic signed [31:0] b,
                                               input logic signed [31:0] c);
      logic signed [31:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                input logic signed [31:0] hi);
      if (v < 0)  return '0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Min edge rounds up (ceil), max edge rounds down (floor) to sample centres.
   always_comb begin
      xmin_u = (min3(q_ax_reg, q_bx_reg, q_cx_reg) + 32'sh0000FFFF) >>> 16;
      xmax_u = max3(q_ax_reg, q_bx_reg, q_cx_reg) >>> 16;
      ymin_u = (min3(q_ay_reg, q_by_reg, q_cy_reg) + 32'sh0000FFFF) >>> 16;
      ymax_u = max3(q_ay_reg, q_by_reg, q_cy_reg) >>> 16;
      xmin_c = clamp(xmin_u, X_LIM);
      xmax_c = clamp(xmax_u, X_LIM);
      ymin_c = clamp(ymin_u, Y_LIM);
      ymax_c = clamp(ymax_u, Y_LIM);
      box_empty = (xmin_u > xmax_u) || (ymin_u > ymax_u) ||
                  (xmin_u > X_LIM) || (xmax_u < 0) ||
                  (ymin_u > Y_LIM) || (ymax_u < 0);
   end

   always_comb begin
      x_next = x_reg + CORDW'(1);
      y_next = y_reg;
      if (x_reg == xmax_reg) begin
         x_next = xmin_reg;
         y_next = y_reg + CORDW'(1);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         state_reg     <= IDLE;
         tri_ready_reg <= 1'b1;
         pix_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         pix_first_reg <= 1'b0;
         pix_last_reg  <= 1'b0;
         x_reg         <= '0;
         y_reg         <= '0;
         xmin_reg      <= '0;
         xmax_reg      <= '0;
         ymin_reg      <= '0;
         ymax_reg      <= '0;
         q_ax_reg      <= '0;
         q_ay_reg      <= '0;
         q_az_reg      <= '0;
         q_bx_reg      <= '0;
         q_by_reg      <= '0;
         q_bz_reg      <= '0;
         q_cx_reg      <= '0;
         q_cy_reg      <= '0;
         q_cz_reg      <= '0;
         q_a_color_reg <= '0;
         q_b_color_reg <= '0;
         q_c_color_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.tri_valid && tri_ready_reg) begin
                  q_ax_reg      <= bus.tri_ax;
                  q_ay_reg      <= bus.tri_ay;
                  q_az_reg      <= bus.tri_az;
                  q_bx_reg      <= bus.tri_bx;
                  q_by_reg      <= bus.tri_by;
                  q_bz_reg      <= bus.tri_bz;
                  q_cx_reg      <= bus.tri_cx;
                  q_cy_reg      <= bus.tri_cy;
                  q_cz_reg      <= bus.tri_cz;
                  q_a_color_reg <= bus.tri_a_color;
                  q_b_color_reg <= bus.tri_b_color;
                  q_c_color_reg <= bus.tri_c_color;
                  tri_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= SETUP;
               end
            end
            SETUP: begin
               if (box_empty) begin
                  done_reg      <= 1'b1;
                  busy_reg      <= 1'b0;
                  tri_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  x_reg         <= CORDW'(xmin_c);
                  y_reg         <= CORDW'(ymin_c);
                  xmin_reg      <= CORDW'(xmin_c);
                  xmax_reg      <= CORDW'(xmax_c);
                  ymin_reg      <= CORDW'(ymin_c);
                  ymax_reg      <= CORDW'(ymax_c);
                  pix_first_reg <= 1'b1;
                  pix_last_reg  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
                  pix_valid_reg <= 1'b1;
                  state_reg     <= SCAN;
               end
            end
            SCAN: begin
               if (bus.pix_ready) begin
                  if (pix_last_reg) begin
                     pix_valid_reg <= 1'b0;
                     done_reg      <= 1'b1;
                     busy_reg      <= 1'b0;
                     tri_ready_reg <= 1'b1;
                     state_reg     <= IDLE;
                  end else begin
                     x_reg         <= x_next;
                     y_reg         <= y_next;
                     pix_first_reg <= 1'b0;
                     pix_last_reg  <= (x_next == xmax_reg) && (y_next == ymax_reg);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.tri_ready = tri_ready_reg & rst_pix_n;
   assign bus.pix_valid = pix_valid_reg;
   assign bus.pix_x     = x_reg;
   assign bus.pix_y     = y_reg;
   assign bus.pix_px    = 32'(x_reg) << 16;
   assign bus.pix_py    = 32'(y_reg) << 16;
   assign bus.pix_first = pix_first_reg;
   assign bus.pix_last  = pix_last_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = busy_reg;
   assign bus.q_ax      = q_ax_reg;
   assign bus.q_ay      = q_ay_reg;
   assign bus.q_az      = q_az_reg;
   assign bus.q_bx      = q_bx_reg;
   assign bus.q_by      = q_by_reg;
   assign bus.q_bz      = q_bz_reg;
   assign bus.q_cx      = q_cx_reg;
   assign bus.q_cy      = q_cy_reg;
   assign bus.q_cz      = q_cz_reg;
   assign bus.q_a_color = q_a_color_reg;
   assign bus.q_b_color = q_b_color_reg;
   assign bus.q_c_color = q_c_color_reg;
endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Scoreboard bench for tri_bbox_scanner: stimulus queues expected pixels and
// done pulses, a negedge monitor pops and compares them.
module tb_tri_bbox_scanner;
   localparam int CORDW = 10;

   typedef struct packed {
      logic [CORDW-1:0] x;
      logic [CORDW-1:0] y;
      logic             first;
      logic             last;
   } pix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tri_bbox_scanner_if #(.CORDW(CORDW)) bus();

   tri_bbox_scanner #(.CORDW(CORDW), .H_RES(640), .V_RES(480)) dut (
      .clk_pix   (clk),
      .rst_pix_n (rst_n),
      .bus       (bus)
   );

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int          pix_seen = 0;
   int          done_seen = 0;
   bit          rand_ready = 1'b0;
   pix_t        exp_pix[$];
   int          exp_done[$];
   logic [323:0] exp_q = '0;

   pix_t        mon_e, mon_got, prev_p;
   logic [63:0] prev_pp;
   bit          prev_stall = 1'b0;

   task automatic check(input string name, input bit ok, input string detail);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   function automatic logic [323:0] q_now();
      return {bus.q_ax, bus.q_ay, bus.q_az, bus.q_bx, bus.q_by, bus.q_bz,
              bus.q_cx, bus.q_cy, bus.q_cz, bus.q_a_color, bus.q_b_color,
              bus.q_c_color};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pix_ready changes just after the edge so the monitor sees the value used next edge
   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            mon_got = '{x: bus.pix_x, y: bus.pix_y, first: bus.pix_first, last: bus.pix_last};
            if (prev_stall)
               check("stall_hold",
                     bus.pix_valid && mon_got == prev_p && {bus.pix_px, bus.pix_py} == prev_pp,
                     $sformatf("got v=%b x=%0d y=%0d, want held x=%0d y=%0d",
                               bus.pix_valid, mon_got.x, mon_got.y, prev_p.x, prev_p.y));
            if (bus.pix_valid && bus.pix_ready) begin
               pix_seen++;
               if (exp_pix.size() == 0) begin
                  check("extra_pixel", 1'b0,
                        $sformatf("got x=%0d y=%0d, want no pixel", mon_got.x, mon_got.y));
               end else begin
                  mon_e = exp_pix.pop_front();
                  check("pixel",
                        mon_got == mon_e && bus.pix_px == (32'(mon_e.x) << 16) &&
                        bus.pix_py == (32'(mon_e.y) << 16),
                        $sformatf("got x=%0d y=%0d px=%h py=%h f=%b l=%b, want x=%0d y=%0d f=%b l=%b",
                                  mon_got.x, mon_got.y, bus.pix_px, bus.pix_py, mon_got.first,
                                  mon_got.last, mon_e.x, mon_e.y, mon_e.first, mon_e.last));
                  check("q_hold", q_now() == exp_q,
                        $sformatf("got q=%h, want %h", q_now(), exp_q));
               end
            end
            if (bus.done) begin
               done_seen++;
               if (exp_done.size() == 0) begin
                  check("extra_done", 1'b0, "got done pulse, want none");
               end else begin
                  void'(exp_done.pop_front());
                  check("done_after_all_pixels", exp_pix.size() == 0,
                        $sformatf("got %0d pixels outstanding, want 0", exp_pix.size()));
               end
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_p     = mon_got;
            prev_pp    = {bus.pix_px, bus.pix_py};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic send_tri(input logic signed [31:0] ax, input logic signed [31:0] ay,
                           input logic signed [31:0] bx, input logic signed [31:0] by,
                           input logic signed [31:0] cx, input logic signed [31:0] cy,
                           input int x0, input int x1, input int y0, input int y1,
                           input bit empty);
      bit acc;
      acc = 1'b0;
      if (!empty)
         for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
               exp_pix.push_back('{x: CORDW'(x), y: CORDW'(y),
                                   first: (x == x0 && y == y0), last: (x == x1 && y == y1)});
      exp_done.push_back(1);
      exp_q = {ax, ay, ax + 32'sd1, bx, by, bx + 32'sd2, cx, cy, cx + 32'sd3,
               12'hF21, 12'h0E3, 12'h45D};
      bus.tri_ax = ax; bus.tri_ay = ay; bus.tri_az = ax + 32'sd1;
      bus.tri_bx = bx; bus.tri_by = by; bus.tri_bz = bx + 32'sd2;
      bus.tri_cx = cx; bus.tri_cy = cy; bus.tri_cz = cx + 32'sd3;
      bus.tri_a_color = 12'hF21; bus.tri_b_color = 12'h0E3; bus.tri_c_color = 12'h45D;
      bus.tri_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         acc = bus.tri_ready;
         tick();
         if (acc) break;
      end
      bus.tri_valid = 1'b0;
      if (!acc) check("accept_timeout", 1'b0, "got tri_ready low for 20 cycles, want accept");
      check("setup_state", !bus.pix_valid && bus.busy && q_now() == exp_q,
            $sformatf("got v=%b busy=%b q=%h, want v=0 busy=1 q=%h",
                      bus.pix_valid, bus.busy, q_now(), exp_q));
      tick();
      check("accept_to_result", bus.pix_valid == !empty && bus.done == empty,
            $sformatf("got pix_valid=%b done=%b, want %b %b",
                      bus.pix_valid, bus.done, !empty, empty));
      if (empty)
         check("ready_after_reject", bus.tri_ready && !bus.busy,
               $sformatf("got ready=%b busy=%b, want 1 0", bus.tri_ready, bus.busy));
   endtask

   task automatic wait_done(input string name, input int budget);
      int start;
      start = done_seen;
      for (int i = 0; i < budget && done_seen == start; i++) tick();
      tick(); tick(); tick();
      check("done_once", done_seen == start + 1,
            $sformatf("got %0d done pulses, want 1", done_seen - start));
      check("idle_after_done", bus.tri_ready && !bus.busy && !bus.pix_valid,
            $sformatf("got ready=%b busy=%b v=%b, want 1 0 0",
                      bus.tri_ready, bus.busy, bus.pix_valid));
      $display("triangle %s: pixels so far %0d, checks %0d/%0d", name, pix_seen, pass_cnt, chk_cnt);
   endtask

   initial begin
      int base, d0;
      bus.tri_valid = 1'b0;
      bus.tri_ax = '0; bus.tri_ay = '0; bus.tri_az = '0;
      bus.tri_bx = '0; bus.tri_by = '0; bus.tri_bz = '0;
      bus.tri_cx = '0; bus.tri_cy = '0; bus.tri_cz = '0;
      bus.tri_a_color = '0; bus.tri_b_color = '0; bus.tri_c_color = '0;
      tick(); tick();
      check("reset_state",
            !bus.pix_valid && !bus.tri_ready && !bus.done && !bus.busy && !bus.pix_first &&
            !bus.pix_last && bus.pix_x == 0 && bus.pix_px == 0 && q_now() == '0,
            $sformatf("got v=%b rdy=%b done=%b busy=%b f=%b l=%b x=%0d, want all 0",
                      bus.pix_valid, bus.tri_ready, bus.done, bus.busy, bus.pix_first,
                      bus.pix_last, bus.pix_x));
      rst_n = 1'b1;
      #1;
      check("ready_out_of_reset", bus.tri_ready == 1'b1,
            $sformatf("got tri_ready=%b, want 1", bus.tri_ready));

      // large triangle, full throughput: x 100..300, y 50..300
      send_tri(32'sd100 <<< 16, 32'sd50 <<< 16, 32'sd200 <<< 16, 32'sd300 <<< 16,
               32'sd300 <<< 16, 32'sd100 <<< 16, 100, 300, 50, 300, 1'b0);
      wait_done("large", 60000);

      rand_ready = 1'b1;
      send_tri(32'sd100 <<< 16, 32'sd50 <<< 16, 32'sd130 <<< 16, 32'sd60 <<< 16,
               32'sd110 <<< 16, 32'sd70 <<< 16, 100, 130, 50, 70, 1'b0);
      wait_done("random_ready", 5000);
      rand_ready = 1'b0;

      // (-10.5,-5),(20,3),(5,-2): clamps at the low screen edges
      send_tri(-32'sd688128, -32'sd5 <<< 16, 32'sd20 <<< 16, 32'sd3 <<< 16,
               32'sd5 <<< 16, -32'sd2 <<< 16, 0, 20, 0, 3, 1'b0);
      wait_done("clamp_low", 500);

      // (630.5,470),(700,500),(635,475): clamps at the high screen edges
      send_tri(32'sd41320448, 32'sd470 <<< 16, 32'sd700 <<< 16, 32'sd500 <<< 16,
               32'sd635 <<< 16, 32'sd475 <<< 16, 631, 639, 470, 479, 1'b0);
      wait_done("clamp_high", 500);

      // (5,7),(5.5,7.5),(5.75,7): exactly one sample at (5,7)
      send_tri(32'sd5 <<< 16, 32'sd7 <<< 16, 32'sd360448, 32'sd491520,
               32'sd376832, 32'sd7 <<< 16, 5, 5, 7, 7, 1'b0);
      wait_done("single", 50);

      // (5.25,7),(5.5,7),(5.75,8): ceil(xmin)=6 > floor(xmax)=5
      send_tri(32'sd344064, 32'sd7 <<< 16, 32'sd360448, 32'sd7 <<< 16,
               32'sd376832, 32'sd8 <<< 16, 0, 0, 0, 0, 1'b1);
      wait_done("no_sample", 50);

      send_tri(32'sd700 <<< 16, 32'sd10 <<< 16, 32'sd710 <<< 16, 32'sd20 <<< 16,
               32'sd720 <<< 16, 32'sd30 <<< 16, 0, 0, 0, 0, 1'b1);
      wait_done("offscreen", 50);

      // reset after 10 pixels of the large triangle
      base = pix_seen;
      d0 = done_seen;
      send_tri(32'sd100 <<< 16, 32'sd50 <<< 16, 32'sd200 <<< 16, 32'sd300 <<< 16,
               32'sd300 <<< 16, 32'sd100 <<< 16, 100, 300, 50, 300, 1'b0);
      for (int i = 0; i < 100 && pix_seen < base + 10; i++) tick();
      check("ten_pixels", pix_seen == base + 10,
            $sformatf("got %0d pixels, want 10", pix_seen - base));
      rst_n = 1'b0;
      exp_pix.delete();
      exp_done.delete();
      tick();
      check("reset_midscan",
            !bus.pix_valid && !bus.tri_ready && !bus.done && !bus.busy && q_now() == '0,
            $sformatf("got v=%b rdy=%b done=%b busy=%b, want all 0",
                      bus.pix_valid, bus.tri_ready, bus.done, bus.busy));
      tick();
      rst_n = 1'b1;
      #1;
      check("ready_after_release", bus.tri_ready == 1'b1,
            $sformatf("got tri_ready=%b, want 1", bus.tri_ready));
      tick(); tick(); tick();
      check("no_done_on_reset", done_seen == d0,
            $sformatf("got %0d done pulses, want 0", done_seen - d0));
      $display("triangle reset_midscan: abandoned after %0d pixels", pix_seen - base);

      // (9,9),(9.5,9),(9,9.25): one sample at (9,9)
      send_tri(32'sd9 <<< 16, 32'sd9 <<< 16, 32'sd622592, 32'sd9 <<< 16,
               32'sd9 <<< 16, 32'sd606208, 9, 9, 9, 9, 1'b0);
      wait_done("after_reset", 50);

      check("scoreboard_drained", exp_pix.size() == 0 && exp_done.size() == 0,
            $sformatf("got %0d pixels %0d dones left, want 0 0", exp_pix.size(), exp_done.size()));
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish by 3000000, want finish; %0d/%0d checks passed",
               pass_cnt, chk_cnt);
      $fatal(1, "watchdog");
   end
endmodule
